// File: rtl/result_capture_pkg.sv
// Shared defaults and entry layout for the result capture FIFO.
// Defining RESULT_CAPTURE_TSTAMP_EN adds a 16-bit capture timestamp to every entry.
package result_capture_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;
  localparam int TSTAMP_W   = 16;

`ifdef RESULT_CAPTURE_TSTAMP_EN
  localparam int TSTAMP_FIELD_W = TSTAMP_W;
`else
  localparam int TSTAMP_FIELD_W = 0;
`endif

  // Stored entry is {timestamp, data} when the timestamp is built in, else just data.
  function automatic int entry_width(input int data_w);
    return data_w + TSTAMP_FIELD_W;
  endfunction

endpackage

// File: rtl/result_capture_fifo_if.sv
// Valid/ready output port of the result capture FIFO.
// With RESULT_CAPTURE_TSTAMP_EN defined, the port also carries out_tstamp.
interface result_capture_fifo_if
  import result_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef RESULT_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] out_tstamp;

  modport master (output out_valid, output out_data, output out_tstamp, input out_ready);
  modport slave  (input out_valid, input out_data, input out_tstamp, output out_ready);
`else
  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
`endif

endinterface

// File: rtl/result_fifo_mem.sv
// Register-array storage for the capture FIFO: synchronous write, asynchronous read.
// Contents clear on RST so the head reads zero straight out of reset.
module result_fifo_mem #(
  parameter int ENTRY_W = 32,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Storage array write port
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/result_capture_fifo.sv
// Change-detecting capture of the datapath result bus into a first-word-fall-through FIFO.
// Optional RESULT_CAPTURE_TSTAMP_EN tags each entry with a free-running 16-bit cycle count.
module result_capture_fifo
  import result_capture_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] result_in,
  input  logic              capture_en,
  result_capture_fifo_if.master out_if,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam int CNT_W   = ADDR_W + 1;
  localparam int ENTRY_W = entry_width(DATA_W);

  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               overflow_r;
  logic [DATA_W-1:0]  last_val_r;
  logic               first_flag_r;
  logic               push_req_s;
  logic               pop_s;
  logic               full_s;
  logic               push_s;
  logic               drop_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] rd_entry_s;

  // Change detect and push/pop arbitration; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    push_req_s = 1'b0;
    full_s     = 1'b0;
    pop_s      = 1'b0;
    push_s     = 1'b0;
    drop_s     = 1'b0;
    push_req_s = capture_en && (first_flag_r || (result_in != last_val_r));
    full_s     = (count_r == CNT_W'(DEPTH));
    pop_s      = (count_r != CNT_W'(0)) && out_if.out_ready;
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
  end

  // FIFO control state; last_val follows every request so a dropped value is not re-requested.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r     <= {ADDR_W{1'b0}};
      rd_ptr_r     <= {ADDR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
      last_val_r   <= {DATA_W{1'b0}};
      first_flag_r <= 1'b1;
    end else begin
      if (push_req_s) begin
        last_val_r   <= result_in;
        first_flag_r <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef RESULT_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] cycle_r;

  // Free-running capture clock, wraps naturally at 16 bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_r <= {TSTAMP_W{1'b0}};
    end else begin
      cycle_r <= cycle_r + TSTAMP_W'(1);
    end
  end

  assign wr_entry_s        = {cycle_r, result_in};
  assign out_if.out_tstamp = rd_entry_s[ENTRY_W-1 -: TSTAMP_W];
`else
  assign wr_entry_s = result_in;
`endif

  result_fifo_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r),
    .rdata (rd_entry_s)
  );

  assign out_if.out_data  = rd_entry_s[DATA_W-1:0];
  assign out_if.out_valid = (count_r != CNT_W'(0));
  assign count            = count_r;
  assign full             = (count_r == CNT_W'(DEPTH));
  assign overflow         = overflow_r;

endmodule

// File: tb/tb_result_capture_fifo.sv
// Self-checking bench for result_capture_fifo: directed cases plus randomized traffic
// against a queue-based reference model (timestamps checked when RESULT_CAPTURE_TSTAMP_EN is defined).
module tb_result_capture_fifo;

  localparam int DEPTH = 8;

  logic        CLK;
  logic        RST;
  logic [31:0] result_in;
  logic        capture_en;
  logic [3:0]  count;
  logic        full;
  logic        overflow;

  result_capture_fifo_if #(.DATA_W(32)) bus ();

  result_capture_fifo #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .result_in  (result_in),
    .capture_en (capture_en),
    .out_if     (bus),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec;
  int n_miscmp;

  // reference model state
  logic [31:0] m_q[$];
  logic [15:0] m_tq[$];
  logic [31:0] m_last;
  bit          m_first;
  bit          m_ovf;
  logic [15:0] m_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tq.delete();
    m_last  = 32'd0;
    m_first = 1'b1;
    m_ovf   = 1'b0;
    m_cyc   = 16'd0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(m_q[0]));
`ifdef RESULT_CAPTURE_TSTAMP_EN
      chk("out_tstamp", 64'(bus.out_tstamp), 64'(m_tq[0]));
`endif
    end
    chk("count", 64'(count), 64'(m_q.size()));
    chk("full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // Called just after a falling edge: drive, let one rising edge happen, update model, check.
  task automatic step(input logic [31:0] v, input bit cap, input bit rdy);
    bit req;
    bit pop;
    bit was_full;
    result_in     = v;
    capture_en    = cap;
    bus.out_ready = rdy;
    @(posedge CLK);
    req      = cap && (m_first || (v != m_last));
    pop      = (m_q.size() != 0) && rdy;
    was_full = (m_q.size() == DEPTH);
    if (pop) begin
      void'(m_q.pop_front());
      void'(m_tq.pop_front());
    end
    if (req) begin
      m_last  = v;
      m_first = 1'b0;
      if (was_full && !pop) begin
        m_ovf = 1'b1;
      end else begin
        m_q.push_back(v);
        m_tq.push_back(m_cyc);
      end
    end
    m_cyc = m_cyc + 16'd1;
    @(negedge CLK);
    check_outputs();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic drain_expect(input logic [31:0] exp, input string tag);
    chk(tag, 64'(bus.out_data), 64'(exp));
    step(32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] seq2 [5];
    logic [31:0] pop2 [3];
    n_vec      = 0;
    n_miscmp   = 0;
    RST        = 1'b1;
    result_in  = 32'd0;
    capture_en = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // zero is captured once after reset, then ignored as unchanged
    for (int i = 0; i < 3; i++) step(32'h0, 1'b1, 1'b0);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);

    // change-detect ordering
    do_reset();
    seq2 = '{32'h5, 32'h5, 32'h7, 32'h7, 32'h5};
    pop2 = '{32'h5, 32'h7, 32'h5};
    foreach (seq2[i]) step(seq2[i], 1'b1, 1'b0);
    chk("t2_count", 64'(count), 64'd3);
    foreach (pop2[i]) drain_expect(pop2[i], "t2_pop");
    chk("t2_empty", 64'(bus.out_valid), 64'd0);

    // overflow on 9th distinct value, drain order 1..8
    do_reset();
    for (int i = 1; i <= 9; i++) step(32'(i), 1'b1, 1'b0);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_overflow", 64'(overflow), 64'd1);
    for (int i = 1; i <= 8; i++) drain_expect(32'(i), "t3_drain");
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);
    step(32'd0, 1'b0, 1'b1);

    // reset with four entries and overflow set, then first sample of zero is captured
    for (int i = 0; i < 4; i++) step(32'h10 + 32'(i), 1'b1, 1'b0);
    chk("t5_count4", 64'(count), 64'd4);
    do_reset();
    step(32'h0, 1'b1, 1'b0);
    chk("t5_first_zero_count", 64'(count), 64'd1);
    chk("t5_first_zero_data", 64'(bus.out_data), 64'd0);

    // push into a full FIFO while popping
    do_reset();
    for (int i = 1; i <= 8; i++) step(32'(i), 1'b1, 1'b0);
    step(32'hA, 1'b1, 1'b1);
    chk("t4_count", 64'(count), 64'd8);
    chk("t4_overflow", 64'(overflow), 64'd0);
    for (int i = 2; i <= 8; i++) drain_expect(32'(i), "t4_drain");
    drain_expect(32'hA, "t4_last");

    // ignore reads on empty; capture_en low holds change-detect state
    step(32'h0, 1'b0, 1'b1);
    step(32'hA, 1'b1, 1'b0);
    chk("t7_no_repush", 64'(count), 64'd0);

`ifdef RESULT_CAPTURE_TSTAMP_EN
    do_reset();
    for (int c = 0; c < 11; c++) begin
      step((c < 3) ? 32'h0 : ((c < 10) ? 32'h11 : 32'h22), (c >= 3), 1'b0);
    end
    chk("ts_first", 64'(bus.out_tstamp), 64'd3);
    step(32'h22, 1'b1, 1'b1);
    chk("ts_second", 64'(bus.out_tstamp), 64'd10);
`endif

    // randomized traffic with a narrow value range to provoke repeats and fills
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(32'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/result_capture_fifo.md
Name: result_capture_fifo

Overview:
- Downstream consumer of the single-cycle datapath's resultadoTotal bus.
- Samples the 32-bit result every CLK rising edge and keeps only changed values (change-detect).
- Buffers those values in a small first-word-fall-through FIFO.
- Presents them on a valid/ready port for a display, UART or bench scoreboard.

Parameters:
- DATA_W, 32, width of the captured result word
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2
- ADDR_W, $clog2(DEPTH), pointer width; derived, not to be overridden

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- result_in  in  DATA_W  result bus from the datapath (resultadoTotal)
- capture_en  in  1  enables sampling; 0 = ignore result_in
- out_ready  in  1  consumer accepts head word this cycle
- out_valid  out  1  head word present (FIFO not empty)
- out_data  out  DATA_W  head word, valid when out_valid=1
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH
- full  out  1  count==DEPTH
- overflow  out  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Interface is fixed: one clock CLK; RST is asynchronous and active-high. The RST assertion clears state immediately, independent of CLK.
- Reset values:
  - out_valid=0, out_data=0, count=0, full=0, overflow=0
  - read/write pointers = 0
  - last_val register = 0
  - first_flag = 1
- Capture condition, evaluated each rising edge: push_req = capture_en && (first_flag || result_in != last_val).
- On a push_req that is accepted:
  - write result_in at wr_ptr
  - wr_ptr+1, wrapping modulo DEPTH
  - last_val <= result_in
  - first_flag <= 0
- last_val updates on every push_req, even a dropped one, so a stuck full FIFO does not re-request the same value every cycle.
- Pop: pop = out_valid && out_ready. Then rd_ptr+1, wrapping modulo DEPTH.
- FWFT output: out_data = mem[rd_ptr] combinationally from storage; out_valid = (count!=0).
  - A word pushed at edge N is visible on out_data/out_valid after edge N (latency 1 cycle).
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push+pop or on neither
- Full boundary:
  - push_req with count==DEPTH and no pop: word dropped, overflow <= 1.
  - push_req with count==DEPTH and a pop in the same cycle: push accepted, count stays DEPTH, no overflow.
- Empty boundary: out_ready with count==0 is ignored; pointers and count do not change.
- Simultaneous push+pop with count==1: head leaves, new word becomes head next cycle, out_valid stays 1.
- overflow clears only on RST.
- capture_en low: no push. last_val and first_flag are held, so re-enabling with an unchanged result does not push.
- Reset mid-operation: all contents discarded, outputs return to reset values asynchronously. The first sample after release is always captured, even if its value is 0.

Optional Feature:
- Macro: RESULT_CAPTURE_TSTAMP_EN.
- Defined:
  - free-running 16-bit cycle counter, reset to 0, wraps at 0xFFFF → 0
  - each stored entry carries the counter value at capture
  - extra output port out_tstamp [15:0], aligned with out_data
- Undefined: no counter, no out_tstamp port, entry width = DATA_W.

Decomposition:
- Package result_capture_pkg holds:
  - DATA_W and DEPTH defaults
  - TSTAMP_W=16
  - entry layout (data word plus optional timestamp) as a packed type or width localparam
- One natural sub-module, result_fifo_mem: dual-pointer register array with synchronous write and asynchronous read. It carries no control logic; control and change-detect stay in the top.

Test Plan:
- Reset then result_in=0x00000000, capture_en=1 for 3 cycles → one entry 0x0; count=1; out_data=0x0, out_valid=1 after the first edge.
- result_in sequence 0x5,0x5,0x7,0x7,0x5 with out_ready=0 → count=3; popped order 0x5,0x7,0x5.
- out_ready=0, 9 distinct values 0x1..0x9 → full=1 after 8 entries; 9th dropped; overflow=1; drained order 0x1..0x8.
- FIFO full (DEPTH=8), new value 0xA with out_ready=1 same cycle → count stays 8; overflow stays 0; 0xA is last out.
- Assert RST between CLK edges with count=4 → outputs zero immediately. After release, result_in=0x0 is captured (first_flag).
- With RESULT_CAPTURE_TSTAMP_EN defined, values change at cycles 3 and 10 after reset → out_tstamp reads 3 then 10.
